// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit_pkg : shared fetch-stage types and defaults             |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package fetch_unit_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_HALT_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_OUT   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pc_reg : word-aligned program counter with +4 and redirect   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect wins over the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = word_align(target_i);
    end else if (inc_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : single-outstanding instruction fetch FSM to decode    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_valid_i,
  input  logic [XLEN-1:0]     imem_rdata_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_target_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [XLEN-1:0]     id_instr_o,
  output logic [XLEN-1:0]     id_pc_o,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic                halt_o,
  output logic [15:0]         retired_o
);

  fetch_state_e    state_q;
  logic            id_valid_q;
  logic [XLEN-1:0] id_instr_q;
  logic [XLEN-1:0] id_pc_q;
  logic            halt_q;
  logic [15:0]     retired_q;

  logic [XLEN-1:0] pc;
  logic            is_halt_word;
  logic            pc_inc;
  logic            pc_redirect;

  assign is_halt_word = (imem_rdata_i == HALT_WORD);
  assign pc_redirect  = redirect_i && (state_q != ST_HALT);
  assign pc_inc       = (state_q == ST_WAIT) && imem_valid_i && !redirect_i && !is_halt_word;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (pc_inc),
    .redirect_i (pc_redirect),
    .target_i   (redirect_target_i),
    .pc_o       (pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FETCH;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      halt_q     <= 1'b0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!redirect_i) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid_i) begin
            if (redirect_i) begin
              state_q <= ST_FETCH;
            end else if (is_halt_word) begin
              state_q <= ST_HALT;
              halt_q  <= 1'b1;
            end else begin
              state_q    <= ST_OUT;
              id_valid_q <= 1'b1;
              id_instr_q <= imem_rdata_i;
              id_pc_q    <= pc;
            end
          end else if (redirect_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_OUT: begin
          if (id_ready_i && (retired_q != 16'hFFFF)) retired_q <= retired_q + 16'd1;
          if (id_ready_i || redirect_i) begin
            state_q    <= ST_FETCH;
            id_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (imem_valid_i) state_q <= ST_FETCH;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // A redirect in FETCH cancels this cycle's request so only one is ever in flight.
  assign imem_req_o  = (state_q == ST_FETCH) && !rst_i && !redirect_i;
  assign imem_addr_o = pc;
  assign id_valid_o  = id_valid_q;
  assign id_instr_o  = id_instr_q;
  assign id_pc_o     = id_pc_q;
  assign opcode_o    = id_instr_q[OPCODE_W-1:0];
  assign halt_o      = halt_q;
  assign retired_o   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit : directed vector table plus randomized scoreboard   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  opcode;
  logic        halt;
  logic [15:0] retired;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .imem_req_o        (imem_req),
    .imem_addr_o       (imem_addr),
    .imem_valid_i      (imem_valid),
    .imem_rdata_i      (imem_rdata),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .id_valid_o        (id_valid),
    .id_ready_i        (id_ready),
    .id_instr_o        (id_instr),
    .id_pc_o           (id_pc),
    .opcode_o          (opcode),
    .halt_o            (halt),
    .retired_o         (retired)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] target;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_halt;
    logic [15:0] e_ret;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] rd, input logic rr,
                              input logic [31:0] tg, input logic rdy, input logic er,
                              input logic [31:0] ea, input logic eiv, input logic [31:0] ei,
                              input logic [31:0] ep, input logic eh, input logic [15:0] ert);
    vec_t t;
    t.valid = v;  t.rdata = rd;  t.redir = rr;  t.target = tg;  t.ready = rdy;
    t.e_req = er; t.e_addr = ea; t.e_idv = eiv; t.e_instr = ei; t.e_pc = ep;
    t.e_halt = eh; t.e_ret = ert;
    return t;
  endfunction

  // Memory image for the random phase; never equal to the halt word.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) | 32'h1;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; imem_valid = 1'b0; redirect = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req", imem_req, 0);
    check("rst.addr", imem_addr, 32'h0);
    check("rst.id_valid", id_valid, 0);
    check("rst.id_instr", id_instr, 0);
    check("rst.id_pc", id_pc, 0);
    check("rst.opcode", opcode, 0);
    check("rst.halt", halt, 0);
    check("rst.retired", retired, 0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[25];
    ent_t        q[$];
    logic [31:0] exp_pc, oaddr, maddr;
    logic        outstanding, stale, had;
    logic [15:0] ret_exp;
    int          mcnt, idle;

    //                valid rdata          rr  target        rdy req addr          idv instr          id_pc         halt ret
    tbl[0]  = mk(0, 32'h0,          0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         32'h0,         0, 0);
    tbl[1]  = mk(1, 32'h0050_0093,  0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0,         0, 0);
    for (int i = 2; i <= 6; i++)
      tbl[i] = mk(0, 32'h0,         0, 32'h0,         0,  0, 32'h4,         1, 32'h0050_0093, 32'h0,         0, 0);
    tbl[7]  = mk(0, 32'h0,          0, 32'h0,         1,  0, 32'h4,         1, 32'h0050_0093, 32'h0,         0, 0);
    tbl[8]  = mk(0, 32'h0,          0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         32'h0,         0, 1);
    tbl[9]  = mk(1, 32'h0010_8113,  0, 32'h0,         0,  0, 32'h4,         0, 32'h0,         32'h0,         0, 1);
    tbl[10] = mk(0, 32'h0,          1, 32'h40,        1,  0, 32'h8,         1, 32'h0010_8113, 32'h4,         0, 1);
    tbl[11] = mk(0, 32'h0,          0, 32'h0,         0,  1, 32'h40,        0, 32'h0,         32'h0,         0, 2);
    tbl[12] = mk(0, 32'h0,          1, 32'h103,       0,  0, 32'h40,        0, 32'h0,         32'h0,         0, 2);
    tbl[13] = mk(0, 32'h0,          0, 32'h0,         0,  0, 32'h100,       0, 32'h0,         32'h0,         0, 2);
    tbl[14] = mk(1, 32'hDEAD_BEEF,  0, 32'h0,         0,  0, 32'h100,       0, 32'h0,         32'h0,         0, 2);
    tbl[15] = mk(0, 32'h0,          0, 32'h0,         0,  1, 32'h100,       0, 32'h0,         32'h0,         0, 2);
    tbl[16] = mk(1, 32'h1111_1113,  1, 32'hFFFF_FFFF, 0,  0, 32'h100,       0, 32'h0,         32'h0,         0, 2);
    tbl[17] = mk(0, 32'h0,          0, 32'h0,         0,  1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0, 2);
    tbl[18] = mk(1, 32'h0000_0013,  0, 32'h0,         0,  0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0, 2);
    tbl[19] = mk(0, 32'h0,          0, 32'h0,         1,  0, 32'h0,         1, 32'h0000_0013, 32'hFFFF_FFFC, 0, 2);
    tbl[20] = mk(0, 32'h0,          1, 32'h200,       0,  0, 32'h0,         0, 32'h0,         32'h0,         0, 3);
    tbl[21] = mk(0, 32'h0,          0, 32'h0,         0,  1, 32'h200,       0, 32'h0,         32'h0,         0, 3);
    tbl[22] = mk(1, 32'h0,          0, 32'h0,         0,  0, 32'h200,       0, 32'h0,         32'h0,         0, 3);
    tbl[23] = mk(0, 32'h0,          1, 32'h300,       0,  0, 32'h200,       0, 32'h0,         32'h0,         1, 3);
    tbl[24] = mk(0, 32'h0,          0, 32'h0,         0,  0, 32'h200,       0, 32'h0,         32'h0,         1, 3);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      imem_valid = tbl[i].valid;  imem_rdata = tbl[i].rdata;
      redirect = tbl[i].redir;    redirect_target = tbl[i].target;
      id_ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("row%0d.req", i), imem_req, tbl[i].e_req);
      check($sformatf("row%0d.addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("row%0d.id_valid", i), id_valid, tbl[i].e_idv);
      check($sformatf("row%0d.halt", i), halt, tbl[i].e_halt);
      check($sformatf("row%0d.retired", i), retired, tbl[i].e_ret);
      if (tbl[i].e_idv) begin
        check($sformatf("row%0d.id_instr", i), id_instr, tbl[i].e_instr);
        check($sformatf("row%0d.id_pc", i), id_pc, tbl[i].e_pc);
        check($sformatf("row%0d.opcode", i), opcode, {25'h0, tbl[i].e_instr[6:0]});
      end
    end

    // Leave HALT via reset; a stray response in the first FETCH must be ignored.
    do_reset();
    @(posedge clk); #1;
    rst = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h1234_5013;
    @(negedge clk);
    check("post_halt.req", imem_req, 1);
    check("post_halt.addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    imem_valid = 1'b1; imem_rdata = 32'h00A0_0113;
    @(negedge clk);
    check("stray.id_valid", id_valid, 0);
    @(posedge clk); #1;
    imem_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    check("stray.id_valid_out", id_valid, 1);
    check("stray.id_instr", id_instr, 32'h00A0_0113);
    check("stray.id_pc", id_pc, 32'h0);
    @(posedge clk); #1;
    id_ready = 1'b0;
    @(negedge clk);
    check("stray.retired", retired, 1);
    check("stray.next_addr", imem_addr, 32'h4);

    // Randomized run against a transaction-level scoreboard.
    do_reset();
    exp_pc = 32'h0; outstanding = 1'b0; stale = 1'b0; ret_exp = '0;
    oaddr = '0; maddr = '0; mcnt = 0; idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      imem_valid = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = memf(maddr);
        end
      end
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      id_ready        = 1'($urandom_range(0, 1));
      @(negedge clk);

      had = (q.size() > 0);
      check("rnd.retired", retired, ret_exp);
      check("rnd.id_valid", id_valid, had);
      if (had) begin
        check("rnd.id_instr", id_instr, q[0].instr);
        check("rnd.id_pc", id_pc, q[0].pc);
        check("rnd.opcode", opcode, {25'h0, q[0].instr[6:0]});
      end
      if (imem_req) begin
        check("rnd.addr", imem_addr, exp_pc);
        check("rnd.one_outstanding", outstanding, 0);
      end

      if (had) begin
        if (id_ready) begin
          void'(q.pop_front());
          if (ret_exp != 16'hFFFF) ret_exp++;
        end else if (redirect) begin
          void'(q.pop_front());
        end
      end
      if (imem_valid) begin
        if (!(redirect || stale)) begin
          q.push_back('{imem_rdata, oaddr});
          exp_pc = oaddr + 32'd4;
        end
        outstanding = 1'b0;
      end
      if (redirect) begin
        exp_pc = {redirect_target[31:2], 2'b00};
        if (outstanding) stale = 1'b1;
      end
      if (imem_req) begin
        outstanding = 1'b1; stale = 1'b0;
        oaddr = imem_addr;  maddr = imem_addr;
        mcnt = $urandom_range(1, 4);
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd.watchdog: got %0d idle cycles expected at most 40", idle);
        idle = 0;
      end
    end
    check("rnd.progress", retired > 16'd100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter HALT_WORD, default 32'h0000_0000, instruction word that stops fetching.
REQ-003 The unit SHALL use one clock; reset is synchronous and active-high.
REQ-004 Clock  in  1  rising-edge clock for all state.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  byte address of the requested word; bits [1:0] are always 0.
REQ-008 imem_valid  in  1  response strobe; exactly one per accepted request, arriving 1 or more cycles after the request.
REQ-009 imem_rdata  in  32  instruction word, valid only when imem_valid=1.
REQ-010 redirect  in  1  branch taken; pc is replaced by redirect_target.
REQ-011 redirect_target  in  32  new pc; bits [1:0] are ignored and forced to 0.
REQ-012 id_valid  out  1  instruction available to decode.
REQ-013 id_ready  in  1  decode accepts the instruction.
REQ-014 id_instr  out  32  held instruction word.
REQ-015 id_pc  out  32  address of id_instr.
REQ-016 Opcode  out  7  id_instr[6:0], driven to the control decoder.
REQ-017 Halt  out  1  sticky end-of-program flag.
REQ-018 retired  out  16  count of completed id handshakes.

Function
REQ-019 The FSM SHALL have the states FETCH, WAIT, OUT, DRAIN and HALT.
REQ-020 FETCH: imem_req=1 and imem_addr=pc for exactly one cycle, then WAIT.
REQ-021 WAIT: on imem_valid, if imem_rdata==HALT_WORD then HALT, else latch id_instr=imem_rdata and id_pc=pc, set pc=pc+4 (mod 2^32), go to OUT.
REQ-022 OUT: id_valid=1; id_instr, id_pc and Opcode stay stable until id_valid&id_ready; on the handshake the FSM goes to FETCH and retired increments.
REQ-023 Fetch-to-id_valid latency SHALL be 2 cycles with a 1-cycle memory.
REQ-024 retired SHALL saturate at 16'hFFFF.
REQ-025 Redirect in FETCH or OUT: pc=target; next state is FETCH; an un-handshaked OUT instruction is dropped (id_valid=0 the next cycle).
REQ-026 Redirect in OUT coincident with id_ready: the handshake counts (retired increments), then pc=target and the FSM goes to FETCH.
REQ-027 Redirect in WAIT without imem_valid: pc=target, go to DRAIN.
REQ-028 Redirect in WAIT with imem_valid: the response is discarded, pc=target, go to FETCH.
REQ-029 DRAIN: imem_req=0; the next imem_valid is discarded, then FETCH; a further redirect in DRAIN updates pc and stays in DRAIN.
REQ-030 HALT: Halt=1, id_valid=0, imem_req=0; redirect is ignored; only Reset exits.
REQ-031 A redirect SHALL never cause more than one outstanding memory request.

Reset
REQ-032 On Reset: state=FETCH, pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, Opcode=0, Halt=0, retired=0, imem_req=0 during the reset cycle.
REQ-033 Reset asserted mid-operation SHALL abandon any outstanding response; an imem_valid arriving in the first FETCH after reset is ignored.

Structure
REQ-034 A shared package SHALL hold the fetch state enum, XLEN=32, OPCODE_W=7, and the default RESET_PC and HALT_WORD.
REQ-035 The pc register, with its +4 and redirect mux and low-bit masking, SHALL be a sub-module named fetch_pc_reg; the rest is one FSM.

Verification
REQ-036 Reset, 1-cycle memory returning 0x00500093 at 0x0 -> imem_addr=0x0; id_valid in cycle 3; Opcode=7'b0010011; id_pc=0x0; next imem_addr=0x4.
REQ-037 id_ready=0 for 5 cycles in OUT -> id_instr, id_pc and Opcode stable; no imem_req; retired unchanged; then id_ready=1 -> retired=1.
REQ-038 Redirect to 0x103 while in WAIT, response delayed 3 cycles -> DRAIN discards the response; next imem_addr=0x100.
REQ-039 Redirect to 0x40 with id_ready=1 in OUT -> retired increments; next imem_addr=0x40.
REQ-040 Memory returns 0x00000000 -> Halt=1 next cycle; imem_req stays 0; redirect ignored; Reset clears Halt and refetches RESET_PC.
REQ-041 pc=0xFFFFFFFC fetch -> next imem_addr=0x00000000.
